// File: rtl/vram_pkg.sv
// vram_pkg: shared widths, owner codes and write-arbiter state encoding.
// Revision 1.0
`default_nettype none

package vram_pkg;

  localparam int VRAM_ADDR_W = 17;
  localparam int VRAM_DATA_W = 8;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } vram_wr_state_e;

endpackage

`default_nettype wire

// File: rtl/vram_wr_starve_guard.sv
// vram_wr_starve_guard: CPU-priority winner select with a DMA starvation counter.
// Revision 1.0
`default_nettype none

module vram_wr_starve_guard
  import vram_pkg::*;
#(
  parameter int DMA_STARVE_MAX = 4
) (
  input  logic clk100,
  input  logic reset_n,
  input  logic idle_i,
  input  logic fifo_full_i,
  input  logic cpu_req_i,
  input  logic dma_req_i,
  output logic accept_o,
  output logic dma_wins_o
);

  localparam logic [3:0] C_STARVE_MAX = 4'(DMA_STARVE_MAX);

  logic [3:0] starve_q;
  logic [3:0] starve_d;

  assign accept_o   = idle_i && !fifo_full_i && (cpu_req_i || dma_req_i);
  assign dma_wins_o = dma_req_i && (!cpu_req_i || (starve_q == C_STARVE_MAX));

  // Only IDLE decisions move the counter; a full-FIFO stall holds it while DMA waits.
  always_comb begin
    starve_d = starve_q;
    if (idle_i) begin
      if (!dma_req_i) begin
        starve_d = '0;
      end else if (accept_o) begin
        if (dma_wins_o) begin
          starve_d = '0;
        end else if (starve_q != C_STARVE_MAX) begin
          starve_d = starve_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: shares the VRAM write FIFO between CPU and DMA, one push per 2 cycles.
// Revision 1.0 -- optional statistics counters enabled by VRAM_WR_STATS_EN.
`default_nettype none

module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W         = VRAM_ADDR_W,
  parameter int DATA_W         = VRAM_DATA_W,
  parameter int DMA_STARVE_MAX = 4
) (
  input  logic              clk100,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_data,
  output logic              dma_ack,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [ADDR_W-1:0] fifo_wr_addr,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              grant_dma
`ifdef VRAM_WR_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       cpu_wr_count,
  output logic [15:0]       dma_wr_count,
  output logic [15:0]       stall_count
`endif
);

  vram_wr_state_e    state_q;
  logic              wr_en_q;
  logic              cpu_ack_q;
  logic              dma_ack_q;
  logic              grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic w_idle;
  logic w_accept;
  logic w_dma_wins;

  assign w_idle = (state_q == ST_IDLE);

  vram_wr_starve_guard #(
    .DMA_STARVE_MAX(DMA_STARVE_MAX)
  ) u_guard (
    .clk100     (clk100),
    .reset_n    (reset_n),
    .idle_i     (w_idle),
    .fifo_full_i(fifo_full),
    .cpu_req_i  (cpu_req),
    .dma_req_i  (dma_req),
    .accept_o   (w_accept),
    .dma_wins_o (w_dma_wins)
  );

  // WRITE is a mandatory gap cycle so a requester reacting to ack is never re-accepted.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      grant_q   <= OWNER_CPU;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wr_en_q   <= w_accept;
          cpu_ack_q <= w_accept && !w_dma_wins;
          dma_ack_q <= w_accept && w_dma_wins;
          if (w_accept) begin
            state_q <= ST_WRITE;
            grant_q <= w_dma_wins ? OWNER_DMA : OWNER_CPU;
            addr_q  <= w_dma_wins ? dma_addr : cpu_addr;
            data_q  <= w_dma_wins ? dma_data : cpu_data;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          wr_en_q   <= 1'b0;
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign cpu_ack      = cpu_ack_q;
  assign dma_ack      = dma_ack_q;
  assign grant_dma    = grant_q;
  assign fifo_wr_addr = addr_q;
  assign fifo_wr_data = data_q;

`ifdef VRAM_WR_STATS_EN
  logic [15:0] cpu_cnt_q;
  logic [15:0] dma_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      cpu_cnt_q   <= '0;
      dma_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (stats_clr) begin
      cpu_cnt_q   <= '0;
      dma_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (cpu_ack_q) cpu_cnt_q <= cpu_cnt_q + 16'd1;
      if (dma_ack_q) dma_cnt_q <= dma_cnt_q + 16'd1;
      if (w_idle && fifo_full && (cpu_req || dma_req)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign cpu_wr_count = cpu_cnt_q;
  assign dma_wr_count = dma_cnt_q;
  assign stall_count  = stall_cnt_q;
`endif

endmodule

`default_nettype wire
